// File: rtl/rx_header_filter.sv
// rx_header_filter
// Ethernet RX header filter. Consumes de-preambled, CRC-stripped frame bytes
// and accepts a frame only if all of these hold:
//   - its destination is MAC_ADDR or broadcast;
//   - its EtherType matches ETHERTYPE;
//   - it carries at least one payload byte.
// Accepted payload bytes are forwarded at a fixed latency of 2 cycles, with
// start/end markers. The 16-bit frame ID of each accepted frame is captured,
// and accepted/dropped frames are counted with saturating counters.
//
// Optional build macro: RX_PROMISC_EN. When it is defined, the destination
// MAC is not checked. The EtherType and runt checks still apply.
//
// Ports:
//   rx_clk         in   byte clock, rising edge
//   rst            in   synchronous active-high reset
//   rx_data[7:0]   in   frame byte (byte 0 = first destination-MAC byte)
//   rx_en          in   byte valid, contiguous per frame
//   pl_data[7:0]   out  payload byte (holds its value while pl_en is low)
//   pl_en          out  payload byte valid
//   pl_sof         out  first payload byte marker
//   pl_eof         out  last payload byte marker
//   frame_id[15:0] out  ID of the last accepted frame (big-endian)
//   id_valid       out  1-cycle pulse when frame_id updates
//   frames_ok      out  accepted-frame count, saturating
//   frames_dropped out  rejected-frame count, saturating
module rx_header_filter #(
  parameter logic [47:0] MAC_ADDR  = 48'h000A35000102,
  parameter logic [15:0] ETHERTYPE = 16'h0800,
  parameter int unsigned HDR_LEN   = 42,
  parameter int unsigned ID_OFFSET = 25
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_en,
  output logic [7:0]  pl_data,
  output logic        pl_en,
  output logic        pl_sof,
  output logic        pl_eof,
  output logic [15:0] frame_id,
  output logic        id_valid,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

`ifdef RX_PROMISC_EN
  localparam logic PROMISC = 1'b1;
`else
  localparam logic PROMISC = 1'b0;
`endif

  localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);
  localparam logic [10:0] HDR_IDX  = 11'(HDR_LEN);
  localparam logic [10:0] ID_HI    = 11'(ID_OFFSET);
  localparam logic [10:0] ID_LO    = 11'(ID_OFFSET + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  // Station-address byte for header index 0..5, MSB first on the wire.
  function automatic logic [7:0] mac_byte(input logic [10:0] idx);
    case (idx)
      11'd0:   return MAC_ADDR[47:40];
      11'd1:   return MAC_ADDR[39:32];
      11'd2:   return MAC_ADDR[31:24];
      11'd3:   return MAC_ADDR[23:16];
      11'd4:   return MAC_ADDR[15:8];
      11'd5:   return MAC_ADDR[7:0];
      default: return 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        en_prev_q, en_prev_d;
  logic [10:0] cnt_q, cnt_d;
  logic        mac_mm_q, mac_mm_d;
  logic        bc_mm_q, bc_mm_d;
  logic        type_mm_q, type_mm_d;
  logic [15:0] id_shadow_q, id_shadow_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_vld_q, hold_vld_d;
  logic        hold_sof_q, hold_sof_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_en_q, pl_en_d;
  logic        pl_sof_q, pl_sof_d;
  logic        pl_eof_q, pl_eof_d;
  logic [15:0] frame_id_q, frame_id_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_dropped_q, frames_dropped_d;

  logic        frame_start_s;
  logic        in_frame_s;
  logic [10:0] idx_s;
  logic        reject_s;
  logic        accept_s;
  logic        drop_s;
  logic        pay_byte_s;

  // Byte position tracking: index of the current byte and the saturating byte count.
  always_comb begin
    frame_start_s = rx_en & ~en_prev_q;
    // Bytes seen in IDLE without a frame start are the tail of a frame cut by reset.
    in_frame_s    = rx_en & (frame_start_s | (state_q != S_IDLE));
    idx_s         = frame_start_s ? 11'd0 : cnt_q;
    en_prev_d     = rx_en;
    if (in_frame_s) begin
      cnt_d = (idx_s == 11'h7FF) ? idx_s : idx_s + 11'd1;
    end else if (!rx_en) begin
      cnt_d = 11'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sticky per-frame header mismatch flags, including the byte being consumed now.
  always_comb begin
    mac_mm_d  = (frame_start_s ? 1'b0 : mac_mm_q)
              | (in_frame_s & (idx_s < 11'd6) & (rx_data != mac_byte(idx_s)));
    bc_mm_d   = (frame_start_s ? 1'b0 : bc_mm_q)
              | (in_frame_s & (idx_s < 11'd6) & (rx_data != 8'hFF));
    type_mm_d = (frame_start_s ? 1'b0 : type_mm_q)
              | (in_frame_s & (idx_s == 11'd12) & (rx_data != ETHERTYPE[15:8]))
              | (in_frame_s & (idx_s == 11'd13) & (rx_data != ETHERTYPE[7:0]));
    reject_s  = (mac_mm_d & bc_mm_d & ~PROMISC) | type_mm_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = frame_start_s ? S_HDR : S_IDLE;
      S_HDR: begin
        if (!rx_en) begin
          state_d = S_IDLE;
        end else if (idx_s == HDR_LAST) begin
          state_d = reject_s ? S_DROP : S_PAYLOAD;
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAYLOAD: state_d = rx_en ? S_PAYLOAD : S_IDLE;
      S_DROP:    state_d = rx_en ? S_DROP : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: frame verdict events and payload-byte strobe.
  always_comb begin
    accept_s   = 1'b0;
    drop_s     = 1'b0;
    pay_byte_s = 1'b0;
    case (state_q)
      S_IDLE:    drop_s = 1'b0;
      S_HDR:     drop_s = ~rx_en;
      S_PAYLOAD: begin
        pay_byte_s = rx_en;
        // A frame ending right after its last header byte has no payload: a runt.
        accept_s   = ~rx_en & (cnt_q > HDR_IDX);
        drop_s     = ~rx_en & (cnt_q <= HDR_IDX);
      end
      S_DROP:    drop_s = ~rx_en;
      default:   drop_s = 1'b0;
    endcase
  end

  // Payload pipeline, ID capture and counters.
  always_comb begin
    hold_vld_d  = pay_byte_s;
    hold_data_d = pay_byte_s ? rx_data : hold_data_q;
    hold_sof_d  = pay_byte_s & (cnt_q == HDR_IDX);
    pl_en_d     = hold_vld_q;
    pl_data_d   = hold_vld_q ? hold_data_q : pl_data_q;
    pl_sof_d    = hold_vld_q & hold_sof_q;
    // The held byte is the last one when rx_en dropped right after it.
    pl_eof_d    = hold_vld_q & ~rx_en;

    if (in_frame_s && (idx_s == ID_HI)) begin
      id_shadow_d = {rx_data, id_shadow_q[7:0]};
    end else if (in_frame_s && (idx_s == ID_LO)) begin
      id_shadow_d = {id_shadow_q[15:8], rx_data};
    end else begin
      id_shadow_d = id_shadow_q;
    end

    frame_id_d       = accept_s ? id_shadow_q : frame_id_q;
    id_valid_d       = accept_s;
    frames_ok_d      = (accept_s && (frames_ok_q != 16'hFFFF)) ?
                       frames_ok_q + 16'd1 : frames_ok_q;
    frames_dropped_d = (drop_s && (frames_dropped_q != 16'hFFFF)) ?
                       frames_dropped_q + 16'd1 : frames_dropped_q;
  end

  // State register for all flops; en_prev resets high to ignore an in-progress frame.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      en_prev_q        <= 1'b1;
      cnt_q            <= 11'd0;
      mac_mm_q         <= 1'b0;
      bc_mm_q          <= 1'b0;
      type_mm_q        <= 1'b0;
      id_shadow_q      <= 16'h0000;
      hold_data_q      <= 8'h00;
      hold_vld_q       <= 1'b0;
      hold_sof_q       <= 1'b0;
      pl_data_q        <= 8'h00;
      pl_en_q          <= 1'b0;
      pl_sof_q         <= 1'b0;
      pl_eof_q         <= 1'b0;
      frame_id_q       <= 16'h0000;
      id_valid_q       <= 1'b0;
      frames_ok_q      <= 16'h0000;
      frames_dropped_q <= 16'h0000;
    end else begin
      state_q          <= state_d;
      en_prev_q        <= en_prev_d;
      cnt_q            <= cnt_d;
      mac_mm_q         <= mac_mm_d;
      bc_mm_q          <= bc_mm_d;
      type_mm_q        <= type_mm_d;
      id_shadow_q      <= id_shadow_d;
      hold_data_q      <= hold_data_d;
      hold_vld_q       <= hold_vld_d;
      hold_sof_q       <= hold_sof_d;
      pl_data_q        <= pl_data_d;
      pl_en_q          <= pl_en_d;
      pl_sof_q         <= pl_sof_d;
      pl_eof_q         <= pl_eof_d;
      frame_id_q       <= frame_id_d;
      id_valid_q       <= id_valid_d;
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign pl_data        = pl_data_q;
  assign pl_en          = pl_en_q;
  assign pl_sof         = pl_sof_q;
  assign pl_eof         = pl_eof_q;
  assign frame_id       = frame_id_q;
  assign id_valid       = id_valid_q;
  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_rx_header_filter.sv
// Self-checking bench for rx_header_filter. It builds frames in byte
// arrays. Each frame's verdict, payload, ID and counters are derived from
// the frame contents using the acceptance rules. The bench then compares
// them against what the DUT emits.
module tb_rx_header_filter;
  localparam logic [47:0] MAC_ADDR  = 48'h000A35000102;
  localparam logic [15:0] ETHERTYPE = 16'h0800;
  localparam int          HDR_LEN   = 42;
  localparam int          ID_OFFSET = 25;
`ifdef RX_PROMISC_EN
  localparam bit PROMISC = 1'b1;
`else
  localparam bit PROMISC = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic [7:0]  pl_data;
  logic        pl_en, pl_sof, pl_eof;
  logic [15:0] frame_id;
  logic        id_valid;
  logic [15:0] frames_ok, frames_dropped;

  rx_header_filter dut (
    .rx_clk(rx_clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en),
    .pl_data(pl_data), .pl_en(pl_en), .pl_sof(pl_sof), .pl_eof(pl_eof),
    .frame_id(frame_id), .id_valid(id_valid),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  // Output monitor: records every payload beat and counts id_valid pulses.
  logic [7:0] mon_data[$];
  logic       mon_sof[$];
  logic       mon_eof[$];
  int         mon_cyc[$];
  int         id_pulses = 0;
  always @(negedge rx_clk) begin
    if (pl_en) begin
      mon_data.push_back(pl_data);
      mon_sof.push_back(pl_sof);
      mon_eof.push_back(pl_eof);
      mon_cyc.push_back(cyc);
    end
    if (id_valid) id_pulses = id_pulses + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state.
  logic [15:0] m_ok, m_drop, m_id;
  logic [7:0]  m_last_pl;
  logic [7:0]  frm [0:255];
  int          in_cyc [0:255];

  task automatic step();
    @(negedge rx_clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_sof.delete(); mon_eof.delete(); mon_cyc.delete();
  endtask

  // kind: 0 station MAC, 1 broadcast, 2 foreign MAC, 3 station MAC with one byte corrupted
  task automatic build(input int kind, input logic [15:0] et, input int len, input logic [15:0] id);
    logic [47:0] dst;
    int k;
    for (int i = 0; i < 256; i++) frm[i] = 8'($urandom);
    case (kind)
      0:       dst = MAC_ADDR;
      1:       dst = 48'hFFFF_FFFF_FFFF;
      2:       dst = 48'h0011_2233_4455;
      default: begin
        dst = MAC_ADDR;
        k = $urandom_range(0, 5);
        dst[8*k +: 8] = dst[8*k +: 8] ^ 8'($urandom_range(1, 255));
      end
    endcase
    for (int i = 0; i < 6; i++) frm[i] = dst[8*(5-i) +: 8];
    frm[12] = et[15:8];
    frm[13] = et[7:0];
    frm[ID_OFFSET]     = id[15:8];
    frm[ID_OFFSET + 1] = id[7:0];
    if (len < 1) $display("bench: bad length %0d", len);
  endtask

  task automatic send_frame(input int len, input int gap);
    logic        acc;
    logic [47:0] dst;
    int          base_id, exp_beats, n;
    clear_mon();
    base_id = id_pulses;
    for (int i = 0; i < len; i++) begin
      rx_en = 1'b1; rx_data = frm[i]; in_cyc[i] = cyc;
      step();
    end
    rx_en = 1'b0; rx_data = 8'h00;
    step();
    // Verdict from the frame contents.
    dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    acc = (len > HDR_LEN) && ({frm[12], frm[13]} == ETHERTYPE) &&
          (PROMISC || dst == MAC_ADDR || dst == 48'hFFFF_FFFF_FFFF);
    if (acc) begin
      if (m_ok != 16'hFFFF) m_ok = m_ok + 16'd1;
      m_id = {frm[ID_OFFSET], frm[ID_OFFSET + 1]};
      m_last_pl = frm[len-1];
      exp_beats = len - HDR_LEN;
    end else begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      exp_beats = 0;
    end
    check_val("beats", 32'(mon_data.size()), 32'(exp_beats));
    n = (mon_data.size() < exp_beats) ? mon_data.size() : exp_beats;
    for (int j = 0; j < n; j++) begin
      check_val("pl_data", 32'(mon_data[j]), 32'(frm[HDR_LEN + j]));
      check_val("pl_sof", 32'(mon_sof[j]), 32'(j == 0));
      check_val("pl_eof", 32'(mon_eof[j]), 32'(j == exp_beats - 1));
      check_val("latency", 32'(mon_cyc[j] - in_cyc[HDR_LEN + j]), 32'd2);
    end
    check_val("id_pulses", 32'(id_pulses - base_id), 32'(acc));
    check_val("frame_id", 32'(frame_id), 32'(m_id));
    check_val("frames_ok", 32'(frames_ok), 32'(m_ok));
    check_val("frames_dropped", 32'(frames_dropped), 32'(m_drop));
    if (!acc) check_val("pl_data_hold", 32'(pl_data), 32'(m_last_pl));
    for (int g = 1; g < gap; g++) step();
  endtask

  initial begin
    logic [15:0] et;
    int          len, sel;
    rst = 1'b1; rx_en = 1'b0; rx_data = 8'h00;
    m_ok = 16'h0; m_drop = 16'h0; m_id = 16'h0; m_last_pl = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_val("reset_outputs",
              {5'd0, pl_en, pl_sof, pl_eof, id_valid, pl_data, 16'h0},
              32'd0);
    check_val("reset_counters", {frames_ok, frames_dropped}, 32'd0);
    check_val("reset_frame_id", 32'(frame_id), 32'd0);

    // Directed frames.
    build(0, 16'h0800, 60, 16'h1234); send_frame(60, 1);
    build(2, 16'h0800, 60, 16'h5678); send_frame(60, 2);
    build(1, 16'h86DD, 60, 16'h1111); send_frame(60, 1);
    build(1, 16'h0800, 60, 16'h2222); send_frame(60, 1);
    build(0, 16'h0800, 30, 16'h3333); send_frame(30, 1);
    build(0, 16'h0800, 60, 16'h4444); send_frame(60, 1);
    build(0, 16'h0800, HDR_LEN, 16'h5555);     send_frame(HDR_LEN, 1);
    build(0, 16'h0800, HDR_LEN + 1, 16'h6666); send_frame(HDR_LEN + 1, 1);
    build(0, 16'h0800, HDR_LEN - 1, 16'h7777); send_frame(HDR_LEN - 1, 2);
    build(0, 16'h0800, 1, 16'h8888);           send_frame(1, 1);
    build(3, 16'h0800, 60, 16'h9999);          send_frame(60, 1);

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(0, 5);
      et  = (sel < 4) ? 16'h0800 : ((sel == 4) ? 16'h86DD : 16'($urandom));
      sel = $urandom_range(0, 3);
      len = (sel == 0) ? $urandom_range(HDR_LEN - 1, HDR_LEN + 2) : $urandom_range(1, 120);
      build($urandom_range(0, 3), et, len, 16'($urandom));
      send_frame(len, $urandom_range(1, 3));
    end

    // Reset in the middle of a good frame, then a normal frame.
    build(0, 16'h0800, 60, 16'hBEEF);
    for (int i = 0; i < 60; i++) begin
      rx_en = 1'b1; rx_data = frm[i]; rst = (i == 50);
      step();
      if (i == 50) begin
        rst = 1'b0;
        check_val("rst_pl_en", 32'(pl_en), 32'd0);
        check_val("rst_counters", {frames_ok, frames_dropped}, 32'd0);
        check_val("rst_frame_id", 32'(frame_id), 32'd0);
        m_ok = 16'h0; m_drop = 16'h0; m_id = 16'h0; m_last_pl = 8'h00;
        clear_mon();
      end
    end
    rx_en = 1'b0;
    step(); step();
    check_val("rst_tail_beats", 32'(mon_data.size()), 32'd0);
    check_val("rst_tail_counters", {frames_ok, frames_dropped}, 32'd0);
    build(0, 16'h0800, 64, 16'hCAFE); send_frame(64, 1);

    // Saturation of the accepted counter.
    force dut.frames_ok_q = 16'hFFFF;
    step(); step();
    release dut.frames_ok_q;
    step();
    m_ok = 16'hFFFF;
    check_val("ok_preload", 32'(frames_ok), 32'hFFFF);
    build(0, 16'h0800, 60, 16'hABCD); send_frame(60, 1);
    build(1, 16'h0800, 50, 16'hDCBA); send_frame(50, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
